// File: rtl/cache_block_xfer_buffer_pkg.sv
// Shared types and constants for the L1/L2 cache block transfer buffer.
package cache_block_xfer_buffer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_FILL  = 3'd1,
        WR_SEND  = 3'd2,
        RD_REQ   = 3'd3,
        RD_DRAIN = 3'd4,
        DONE     = 3'd5
    } xferState_t;

    localparam int DEF_BLOCK_WORDS = 4;

    // exception_bus_o bit positions
    localparam int EXC_WR_STROBE = 0;
    localparam int EXC_RD_STROBE = 1;
    localparam int EXC_MEM_VALID = 2;
    localparam int EXC_TIMEOUT   = 3;

endpackage

// File: rtl/cache_block_xfer_buffer_xfer_fifo.sv
// First-word fall-through FIFO staging one cache block between L1 and L2.
module xfer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      count;
    logic             doPush, doPop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign data_o  = mem[rdPtr];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (doPush) mem[wrPtr] <= data_i;
    end

endmodule

// File: rtl/cache_block_xfer_buffer.sv
// L1<->L2 word/block transfer buffer with sticky error flags.
// Optional watchdog enabled by defining XFER_TIMEOUT_EN.
module cache_block_xfer_buffer
    import cache_block_xfer_buffer_pkg::*;
#(
    parameter int BLOCK_WORDS    = DEF_BLOCK_WORDS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        reqBlock_i,
    input  logic        rw_i,
    input  logic [23:0] add_i,
    input  logic [31:0] data_i,
    input  logic        write_en_i,
    input  logic        read_ack_i,
    output logic        ready_write_o,
    output logic        ready_read_o,
    output logic [31:0] data_o,
    output logic        mem_req_o,
    output logic        mem_reqBlock_o,
    output logic        mem_rw_o,
    output logic        mem_write_o,
    output logic        mem_clear_o,
    output logic [23:0] mem_add_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ready_i,
    input  logic        mem_valid_i,
    input  logic        mem_done_i,
    input  logic [31:0] mem_data_i,
    output logic [3:0]  exception_bus_o
);

    localparam int          CW       = $clog2(BLOCK_WORDS) + 1;
    localparam logic [23:0] ADD_MASK = ~24'(BLOCK_WORDS - 1);

    if ((BLOCK_WORDS < 2) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : gBadParams
        $error("cache_block_xfer_buffer: BLOCK_WORDS must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
    end

    xferState_t    state, stateNext;
    logic          rwQ, blockQ, clrSent, rdState, timeoutHit;
    logic [23:0]   addQ;
    logic [CW-1:0] pushCnt, popCnt, nWords;
    logic          fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [31:0]   fifoDin, fifoHead;
    logic [3:0]    excQ, excSet;

    assign nWords          = blockQ ? CW'(BLOCK_WORDS) : CW'(1);
    assign rdState         = (state == RD_REQ) || (state == RD_DRAIN);
    assign exception_bus_o = excQ;

    always_comb begin
        stateNext      = state;
        ready_write_o  = (state == WR_FILL) && (pushCnt < nWords);
        ready_read_o   = rdState && !fifoEmpty;
        // request stays up through the cycle that moves the last word
        mem_req_o      = ((state == WR_SEND) && (popCnt < nWords)) || (rdState && (pushCnt < nWords));
        mem_write_o    = (state == WR_SEND) && (popCnt < nWords) && mem_ready_i && !fifoEmpty;
        mem_rw_o       = mem_req_o && rwQ;
        mem_reqBlock_o = mem_req_o && blockQ;
        mem_add_o      = mem_req_o ? addQ : '0;
        mem_data_o     = mem_write_o ? fifoHead : '0;
        data_o         = ready_read_o ? fifoHead : '0;
        mem_clear_o    = (state == DONE) && !clrSent;
        fifoDin        = rdState ? mem_data_i : data_i;
        fifoPush       = rdState ? (mem_valid_i && !fifoFull && (pushCnt < nWords))
                                 : (write_en_i && ready_write_o);
        fifoPop        = mem_write_o || (read_ack_i && ready_read_o);

        case (state)
            IDLE:     if (req_i) stateNext = rw_i ? WR_FILL : RD_REQ;
            WR_FILL:  if (fifoPush && (pushCnt + 1'b1 == nWords)) stateNext = WR_SEND;
            WR_SEND:  if (mem_done_i && (popCnt == nWords)) stateNext = DONE;
            RD_REQ:   if (fifoPush) stateNext = RD_DRAIN;
            RD_DRAIN: if (fifoPop && (popCnt + 1'b1 == nWords)) stateNext = DONE;
            DONE:     if (!req_i) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
        if (timeoutHit) stateNext = IDLE;
    end

    always_comb begin
        excSet                = '0;
        excSet[EXC_WR_STROBE] = write_en_i && !ready_write_o;
        excSet[EXC_RD_STROBE] = read_ack_i && !ready_read_o;
        excSet[EXC_MEM_VALID] = mem_valid_i && (!rdState || fifoFull);
        excSet[EXC_TIMEOUT]   = timeoutHit;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            rwQ     <= 1'b0;
            blockQ  <= 1'b0;
            addQ    <= '0;
            pushCnt <= '0;
            popCnt  <= '0;
            clrSent <= 1'b0;
            excQ    <= '0;
        end else begin
            state   <= stateNext;
            excQ    <= excQ | excSet;
            clrSent <= (state == DONE);
            if (state == IDLE) begin
                pushCnt <= '0;
                popCnt  <= '0;
                if (req_i) begin
                    rwQ    <= rw_i;
                    blockQ <= reqBlock_i;
                    addQ   <= reqBlock_i ? (add_i & ADD_MASK) : add_i;
                end
            end else begin
                if (fifoPush) pushCnt <= pushCnt + 1'b1;
                if (fifoPop)  popCnt  <= popCnt + 1'b1;
            end
        end
    end

`ifdef XFER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wdCnt;
    logic          wdActive;

    // any push, pop or completion counts as forward progress
    assign wdActive   = fifoPush || fifoPop || mem_done_i;
    assign timeoutHit = (state != IDLE) && !wdActive && (wdCnt + 1'b1 == WW'(TIMEOUT_CYCLES));

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)                        wdCnt <= '0;
        else if ((state == IDLE) || wdActive) wdCnt <= '0;
        else                                  wdCnt <= wdCnt + 1'b1;
    end
`else
    assign timeoutHit = 1'b0;
`endif

    xfer_fifo #(
        .DEPTH (BLOCK_WORDS),
        .WIDTH (32)
    ) uFifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush_i (timeoutHit),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  (fifoDin),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

endmodule

// File: doc/cache_block_xfer_buffer.md
CACHE_BLOCK_XFER_BUFFER -- requirements
Module: cache_block_xfer_buffer

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 4, words per cache block (power of 2, at least 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit used only under XFER_TIMEOUT_EN.
REQ-003 SHALL have port clock_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_i, reqBlock_i, rw_i, input, 1 each, L1-side request, block/word select and direction (1 = write).
REQ-006 SHALL have ports add_i (input, 24, word address) and data_i (input, 32, write data).
REQ-007 SHALL have ports write_en_i and read_ack_i, input, 1 each, L1-side push-write-word and pop-read-word strobes.
REQ-008 SHALL have ports ready_write_o, ready_read_o (output, 1 each) and data_o (output, 32, read head word).
REQ-009 SHALL have L2-side outputs mem_req_o, mem_reqBlock_o, mem_rw_o, mem_write_o, mem_clear_o (1 each), mem_add_o (24) and mem_data_o (32).
REQ-010 SHALL have L2-side inputs mem_ready_i, mem_valid_i, mem_done_i (1 each) and mem_data_i (32).
REQ-011 SHALL have port exception_bus_o, output, 4, sticky error flags.

Function
REQ-012 SHALL implement states IDLE, WR_FILL, WR_SEND, RD_REQ, RD_DRAIN and DONE.
REQ-013 IDLE with req_i=1 SHALL latch rw_i, reqBlock_i and the address, then enter WR_FILL if rw_i=1, else RD_REQ.
REQ-014 SHALL set N = BLOCK_WORDS when reqBlock_i=1, else 1; block addresses SHALL be aligned with the low log2(BLOCK_WORDS) bits forced to 0.
REQ-015 In WR_FILL, ready_write_o SHALL be 1 while fewer than N words are accepted; write_en_i&ready_write_o SHALL push data_i into the FIFO.
REQ-016 After N words are pushed, SHALL enter WR_SEND and assert mem_req_o, mem_rw_o=1 and mem_add_o.
REQ-017 In WR_SEND, each cycle with mem_ready_i=1 and FIFO non-empty SHALL pop the FIFO to mem_data_o with mem_write_o=1 in the same cycle.
REQ-018 In WR_SEND, mem_done_i=1 after all N words are sent SHALL cause entry to DONE.
REQ-019 RD_REQ SHALL assert mem_req_o, mem_rw_o=0; each mem_valid_i=1 SHALL push mem_data_i.
REQ-020 The first pushed word SHALL cause entry to RD_DRAIN; pushes SHALL continue in RD_DRAIN until N words are received.
REQ-021 ready_read_o SHALL equal FIFO non-empty in RD_REQ/RD_DRAIN; data_o SHALL show the FIFO head (first-word fall-through).
REQ-022 read_ack_i&ready_read_o SHALL pop the FIFO; the Nth pop SHALL cause entry to DONE.
REQ-023 mem_req_o SHALL fall in the cycle the last write word is sent or the last read word is received.
REQ-024 DONE SHALL pulse mem_clear_o for one cycle, then wait for req_i=0 before entering IDLE.
REQ-025 Pushes and pops in the same cycle SHALL both take effect; FIFO occupancy SHALL never exceed BLOCK_WORDS.
REQ-026 exception_bus_o bit 0 SHALL set on write_en_i with ready_write_o=0; bit 1 SHALL set on read_ack_i with ready_read_o=0.
REQ-027 exception_bus_o bit 2 SHALL set on mem_valid_i outside RD states or with the FIFO full; that data SHALL be dropped.
REQ-028 Erroneous strobes SHALL NOT change FIFO contents or counters.

Reset
REQ-029 reset_i=0 SHALL immediately force IDLE, an empty FIFO, zero counters, every output at 0 and exception_bus_o=0, including mid-transfer.

Configuration
REQ-030 With XFER_TIMEOUT_EN defined, a counter SHALL count cycles outside IDLE without a push, pop or mem_done_i; reaching TIMEOUT_CYCLES SHALL set exception bit 3 and force IDLE with the FIFO flushed.
REQ-031 Without XFER_TIMEOUT_EN, SHALL have no watchdog logic, and exception bit 3 SHALL be tied to 0.

Structure
REQ-032 The shared package SHALL hold the state enum, the BLOCK_WORDS default and the exception bit indices.
REQ-033 SHALL instantiate one sub-module, xfer_fifo: synchronous, first-word fall-through, depth BLOCK_WORDS, 32-bit, with full/empty outputs.

Verification
REQ-034 Block write: req_i=1, rw_i=1, reqBlock_i=1, add_i=0x000013, four data words 0xA0..0xA3 -> mem_add_o=0x000010; 0xA0..0xA3 appear on mem_data_o in order; one mem_clear_o pulse.
REQ-035 Word read: rw_i=0, reqBlock_i=0, add_i=0x000005, mem_valid_i with 0xDEADBEEF -> ready_read_o=1, data_o=0xDEADBEEF; idle after read_ack_i and req_i=0.
REQ-036 Block read with read_ack_i held 0 until all four mem_valid_i arrive -> no loss; pops yield data in order.
REQ-037 write_en_i in IDLE, and mem_valid_i in WR_FILL -> exception_bus_o=4'b0101; FIFO unchanged.
REQ-038 reset_i=0 after two of four read words -> all outputs 0 next edge; a fresh transfer then completes normally.
REQ-039 With XFER_TIMEOUT_EN and TIMEOUT_CYCLES=16, RD_REQ with no mem_valid_i -> bit 3 set at cycle 16 and state IDLE.
